// File: rtl/mac_pkg.sv
// Shared definitions for the MAC sequencing controller: FSM state
// constants, datapath function codes and the stage-index width helper.
package mac_pkg;

    typedef logic [1:0] mac_state_t;

    localparam mac_state_t ST_IDLE  = 2'd0;
    localparam mac_state_t ST_ISSUE = 2'd1;
    localparam mac_state_t ST_DONE  = 2'd2;

    localparam logic [1:0] FUNC_NOP = 2'd0;
    localparam logic [1:0] FUNC_MUL = 2'd1;
    localparam logic [1:0] FUNC_ACC = 2'd2;
    localparam logic [1:0] FUNC_MAC = 2'd3;

    // Stage index width; a single-stage build still needs one bit.
    function automatic int cnt_width(input int stages);
        return (stages > 1) ? $clog2(stages) : 1;
    endfunction

endpackage

// File: rtl/mac_stage_cnt.sv
// Stage index counter for the MAC sequencer. Cleared when a command is
// accepted, advanced while the datapath is not stalled, and saturates at
// the last stage where it raises the terminal-count flag.
module mac_stage_cnt
    import mac_pkg::*;
#(
    parameter  int STAGES = 2,
    localparam int CNT_W  = cnt_width(STAGES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(STAGES - 1);

    assign tc = (cnt == LAST);

    // Load zero on clear, count up on enable, never wrap past the last stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !tc) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mac_seq_ctrl.sv
// MAC sequencing controller. Accepts a function code, drives it to the
// datapath for STAGES unstalled cycles while stepping the stage index,
// then pulses done for one cycle. A new command may be accepted in the
// done cycle so consecutive commands run without an idle gap.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for a command, cmd_ready high
//   ST_ISSUE | driving func_q to the datapath, one stage per unstalled edge
//   ST_DONE  | one-cycle completion pulse, may accept the next command
module mac_seq_ctrl
    import mac_pkg::*;
#(
    parameter  int FUNC_W = 2,
    parameter  int STAGES = 2,
    localparam int CNT_W  = cnt_width(STAGES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [FUNC_W-1:0] cmd_func,
    input  logic              stall,
    output logic [FUNC_W-1:0] ctrl,
    output logic              ctrl_valid,
    output logic [CNT_W-1:0]  stage,
    output logic              busy,
    output logic              done
);

    mac_state_t        state_q;
    mac_state_t        state_d;
    logic [FUNC_W-1:0] func_q;
    logic [CNT_W-1:0]  cnt;
    logic              cnt_tc;
    logic              accept;
    logic              advance;
    logic              in_issue;

    assign in_issue  = (state_q == ST_ISSUE);
    assign cmd_ready = !in_issue;
    assign accept    = cmd_valid && cmd_ready;
    assign advance   = in_issue && !stall;

    mac_stage_cnt #(
        .STAGES (STAGES)
    ) u_stage_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .en    (advance),
        .cnt   (cnt),
        .tc    (cnt_tc)
    );

    // Next-state decode; the unused encoding falls back to idle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (advance && cnt_tc) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = accept ? ST_ISSUE : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register; reset aborts any command in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the function code only at acceptance so later input changes are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            func_q <= '0;
        end else if (accept) begin
            func_q <= cmd_func;
        end
    end

    // Datapath outputs are decoded purely from flops, so they change only on
    // a clock edge or reset and read as zero outside of ISSUE.
    always_comb begin
        ctrl       = in_issue ? func_q : '0;
        ctrl_valid = in_issue;
        stage      = in_issue ? cnt : '0;
        busy       = in_issue;
        done       = (state_q == ST_DONE);
    end

endmodule

// File: doc/mac_seq_ctrl.md
MAC_SEQ_CTRL -- requirements
Module: mac_seq_ctrl

Interface
REQ-001 SHALL have parameter FUNC_W, default 2: width of the function code.
REQ-002 SHALL have parameter STAGES, default 2, legal range 1..16: number of pipeline stages driven per command.
REQ-003 SHALL have derived parameter CNT_W = max(1, clog2(STAGES)): stage index width.
REQ-004 SHALL have port clk, input, 1: single clock; all state changes on rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port cmd_valid, input, 1: command request.
REQ-007 SHALL have port cmd_ready, output, 1: controller can accept a command.
REQ-008 SHALL have port cmd_func, input, FUNC_W: function code of the command.
REQ-009 SHALL have port stall, input, 1: datapath back-pressure; freezes stage advance.
REQ-010 SHALL have port ctrl, output, FUNC_W: control code to datapath.
REQ-011 SHALL have port ctrl_valid, output, 1: ctrl is meaningful this cycle.
REQ-012 SHALL have port stage, output, CNT_W: index of the stage currently driven.
REQ-013 SHALL have port busy, output, 1: command in progress.
REQ-014 SHALL have port done, output, 1: single-cycle completion pulse.

Function
REQ-015 SHALL implement an FSM with states IDLE, ISSUE and DONE.
REQ-016 SHALL drive cmd_ready = 1 in IDLE and DONE, and 0 in ISSUE, decoded from the state register.
REQ-017 SHALL accept a command on a rising edge where cmd_valid and cmd_ready are both 1: latch cmd_func into func_q, set the stage counter to 0, go to ISSUE.
REQ-018 SHALL, in ISSUE, register ctrl = func_q, ctrl_valid = 1, stage = counter and busy = 1.
REQ-019 SHALL, in ISSUE with stall = 0, advance the counter by 1 per edge; at counter = STAGES-1 it SHALL go to DONE instead.
REQ-020 SHALL, in ISSUE with stall = 1, hold state, counter, ctrl and ctrl_valid unchanged.
REQ-021 SHALL give latency: acceptance at edge N -> ctrl_valid high from after edge N for exactly STAGES unstalled cycles, then done = 1 for exactly one cycle.
REQ-022 SHALL drive ctrl = 0, ctrl_valid = 0, stage = 0 and busy = 0 in IDLE and DONE; outputs are never high-impedance.
REQ-023 SHALL assert done only in DONE; from DONE, go to ISSUE if a command is accepted that edge (back-to-back, no IDLE gap), else to IDLE.
REQ-024 SHALL ignore cmd_func changes and cmd_valid while in ISSUE.
REQ-025 SHALL ignore stall in IDLE and DONE.
REQ-026 SHALL, for STAGES = 1, spend exactly one unstalled ISSUE cycle with stage = 0.

Reset
REQ-027 SHALL, while rst_n = 0, immediately force state IDLE, counter 0, func_q 0, ctrl 0, ctrl_valid 0, stage 0, busy 0 and done 0; cmd_ready reads 1.
REQ-028 SHALL abort an in-progress command on reset, with no done pulse.
REQ-029 SHALL, after rst_n is released, act on the first rising edge with no warm-up cycles.

Structure
REQ-030 SHALL take the state enum (IDLE/ISSUE/DONE) and the function-code constants (e.g. FUNC_NOP = 0, FUNC_MUL = 1, FUNC_ACC = 2, FUNC_MAC = 3) from shared package mac_pkg.
REQ-031 SHALL place the stage counter (load-zero, enable, hold, terminal-count flag) in sub-module mac_stage_cnt, parametrised by STAGES.

Verification
REQ-032 Basic run, STAGES=2: cmd_func=3 accepted at edge 1 -> ctrl=3 and ctrl_valid=1 with stage 0 then 1, done=1 in cycle 3, IDLE in cycle 4.
REQ-033 Stall: STAGES=4, stall=1 for 2 cycles while stage=1 -> stage holds 1 for 3 cycles; ctrl_valid high for 6 cycles total; one done pulse.
REQ-034 Back-to-back: cmd_valid held with func 1 then 2 -> second command accepted in DONE; ctrl sequence 1,1,2,2; two done pulses; no IDLE cycle between.
REQ-035 Ignored input: cmd_func changed from 2 to 1 mid-ISSUE -> ctrl stays 2 until done.
REQ-036 Reset mid-operation: rst_n=0 at stage 1 -> all outputs 0 immediately without a clock edge, cmd_ready=1, no done.
REQ-037 STAGES=1: command func=1 -> one ctrl_valid cycle at stage 0, then done.
